// File: rtl/spi_master_px.sv
// SPI master with clock divider, MSB-first TX/RX shift paths and one-hot active-low slave selects.
// Define SPI_LSB_FIRST_EN to add the lsb_first port for LSB-first transfers.
module spi_master_px #(
    parameter  int DATA_W = 8,
    parameter  int NUM_SS = 4,
    parameter  int DIV_W  = 8,
    localparam int LEN_W  = $clog2(DATA_W) + 1,
    localparam int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [LEN_W-1:0]  xfer_len,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sck,
    output logic              mosi,
    output logic              mosi_oe,
    input  logic              miso,
`ifdef SPI_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic [NUM_SS-1:0] ss_n
);

    localparam int IDX_W  = $clog2(DATA_W);
    localparam int EDGE_W = LEN_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    cnt;
    logic [DIV_W-1:0]    div_r;
    logic [EDGE_W-1:0]   edge_n;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    tx_k;
    logic [LEN_W-1:0]    rx_k;
    logic                cpol_r;
    logic                cpha_r;
    logic                lsb_r;
    logic [DATA_W-1:0]   tx_r;
    logic [DATA_W-1:0]   rx_r;

    logic                lsb_in;
    logic [LEN_W-1:0]    len_eff;
    logic                tick;
    logic [EDGE_W-1:0]   edge_nxt;
    logic                last_edge;
    logic                sample_edge;
    logic                drive_edge;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    // Position of the k-th transferred bit inside the right-aligned word.
    function automatic logic [IDX_W-1:0] bit_pos(input logic lsb,
                                                 input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] k);
        logic [LEN_W-1:0] p;
        p = lsb ? k : (len - LEN_W'(1) - k);
        return p[IDX_W-1:0];
    endfunction

    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SEL_W-1:0] sel);
        logic [NUM_SS-1:0] v;
        v = '1;
        for (int unsigned i = 0; i < NUM_SS; i++) begin
            if (SEL_W'(i) == sel) v[i] = 1'b0;
        end
        return v;
    endfunction

    always_comb begin
        len_eff = xfer_len;
        if (xfer_len == '0 || xfer_len > LEN_W'(DATA_W)) len_eff = LEN_W'(DATA_W);
    end

    assign tick        = (cnt == div_r);
    assign edge_nxt    = edge_n + 1'b1;
    assign last_edge   = (edge_nxt == {len_r, 1'b0});
    // cpha=0 samples on odd edges, cpha=1 on even edges; the other edges drive.
    assign sample_edge = edge_nxt[0] ^ cpha_r;
    assign drive_edge  = !sample_edge && (cpha_r || !last_edge);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            div_r   <= '0;
            edge_n  <= '0;
            len_r   <= '0;
            tx_k    <= '0;
            rx_k    <= '0;
            cpol_r  <= 1'b0;
            cpha_r  <= 1'b0;
            lsb_r   <= 1'b0;
            tx_r    <= '0;
            rx_r    <= '0;
            rx_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            mosi_oe <= 1'b0;
            ss_n    <= '1;
        end else begin
            case (state)
                S_IDLE: begin
                    sck  <= cpol;
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        state   <= S_SETUP;
                        cpol_r  <= cpol;
                        cpha_r  <= cpha;
                        lsb_r   <= lsb_in;
                        div_r   <= clk_div;
                        len_r   <= len_eff;
                        tx_r    <= tx_data;
                        rx_r    <= '0;
                        cnt     <= '0;
                        edge_n  <= '0;
                        rx_k    <= '0;
                        busy    <= 1'b1;
                        mosi_oe <= 1'b1;
                        ss_n    <= ss_decode(ss_sel);
                        if (cpha) begin
                            mosi <= 1'b0;
                            tx_k <= '0;
                        end else begin
                            mosi <= tx_data[bit_pos(lsb_in, len_eff, '0)];
                            tx_k <= LEN_W'(1);
                        end
                    end
                end
                S_SETUP, S_ACTIVE: begin
                    if (tick) begin
                        cnt    <= '0;
                        sck    <= ~sck;
                        edge_n <= edge_nxt;
                        if (sample_edge) begin
                            rx_r[bit_pos(lsb_r, len_r, rx_k)] <= miso;
                            rx_k <= rx_k + 1'b1;
                        end
                        if (drive_edge) begin
                            mosi <= tx_r[bit_pos(lsb_r, len_r, tx_k)];
                            tx_k <= tx_k + 1'b1;
                        end
                        state <= last_edge ? S_HOLD : S_ACTIVE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        cnt     <= '0;
                        state   <= S_DONE;
                        done    <= 1'b1;
                        ss_n    <= '1;
                        mosi_oe <= 1'b0;
                        rx_data <= rx_r;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    sck   <= cpol;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_px.sv
// Scoreboard bench for spi_master_px: randomized and directed transfers against a behavioural SPI slave
// and a transfer-level reference model. Define SPI_LSB_FIRST_EN to also cover LSB-first transfers.
module tb_spi_master_px;

    localparam int DATA_W = 8;
    localparam int NUM_SS = 4;
    localparam int DIV_W  = 8;
    localparam int LEN_W  = 4;
    localparam int SEL_W  = 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic              cpol;
    logic              cpha;
    logic [DIV_W-1:0]  clk_div;
    logic [LEN_W-1:0]  xfer_len;
    logic [SEL_W-1:0]  ss_sel;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;
    logic              sck;
    logic              mosi;
    logic              mosi_oe;
    logic              miso;
    logic [NUM_SS-1:0] ss_n;
`ifdef SPI_LSB_FIRST_EN
    logic              lsb_first;
`endif

    spi_master_px #(.DATA_W(DATA_W), .NUM_SS(NUM_SS), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cpol     (cpol),
        .cpha     (cpha),
        .clk_div  (clk_div),
        .xfer_len (xfer_len),
        .ss_sel   (ss_sel),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .busy     (busy),
        .done     (done),
        .sck      (sck),
        .mosi     (mosi),
        .mosi_oe  (mosi_oe),
        .miso     (miso),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .ss_n     (ss_n)
    );

    typedef struct {
        logic [DATA_W-1:0] rx;
        logic [DATA_W-1:0] txm;
        int                lat;
        int                issue;
        logic [NUM_SS-1:0] ss;
        int                len;
        logic              cpol;
        logic              lsb;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   n_done = 0;

    // Behavioural slave state and the settings of the transfer in flight.
    logic              loop_mode = 1'b1;
    logic              slv_miso  = 1'b0;
    logic              cur_cpol  = 1'b0;
    logic              cur_cpha  = 1'b0;
    logic              cur_lsb   = 1'b0;
    int                cur_len   = DATA_W;
    logic [DATA_W-1:0] slv_word  = '0;
    int                slv_k     = 0;
    bit                slv_cap[$];
    logic              ss_all;

    assign ss_all = &ss_n;
    assign miso   = loop_mode ? mosi : slv_miso;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int eff_len(input int l);
        return (l == 0 || l > DATA_W) ? DATA_W : l;
    endfunction

    function automatic logic sbit(input int k);
        if (k >= cur_len) return 1'b0;
        return cur_lsb ? slv_word[k] : slv_word[cur_len-1-k];
    endfunction

    always @(negedge ss_all) begin
        slv_k = 0;
        slv_cap.delete();
        if (!cur_cpha) slv_miso = sbit(0);
    end

    always @(sck) begin
        if (ss_all === 1'b0) begin
            if (sck != cur_cpol) begin
                if (cur_cpha) begin
                    slv_miso = sbit(slv_k);
                    slv_k++;
                end else begin
                    slv_cap.push_back(mosi);
                end
            end else begin
                if (cur_cpha) begin
                    slv_cap.push_back(mosi);
                end else begin
                    slv_k++;
                    slv_miso = sbit(slv_k);
                end
            end
        end
    end

    // Monitor: tracks SCK/select activity while busy and scores each done pulse.
    initial begin
        int   rises;
        bit   ss_bad;
        logic prev_sck;
        exp_t e;
        logic [31:0] v;
        rises = 0; ss_bad = 0; prev_sck = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                rises = 0;
                ss_bad = 0;
            end else begin
                if (busy && !done) begin
                    if (sck && !prev_sck) rises++;
                    if (sb_q.size() > 0 && ss_n !== sb_q[0].ss) ss_bad = 1;
                end
                if (done) begin
                    n_done++;
                    if (sb_q.size() == 0) begin
                        chk("spurious_done", 32'(done), 32'(0));
                    end else begin
                        e = sb_q.pop_front();
                        chk("rx_data", 32'(rx_data), 32'(e.rx));
                        chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                        chk("sck_rises", 32'(rises), 32'(e.len));
                        chk("ss_during_xfer", 32'(ss_bad), 32'(0));
                        chk("ss_at_done", 32'(ss_n), 32'({NUM_SS{1'b1}}));
                        chk("sck_idle_at_done", 32'(sck), 32'(e.cpol));
                        chk("mosi_oe_at_done", 32'(mosi_oe), 32'(0));
                        chk("busy_at_done", 32'(busy), 32'(1));
                        v = '0;
                        for (int i = 0; i < slv_cap.size(); i++) begin
                            if (e.lsb) v = v | (32'(slv_cap[i]) << i);
                            else       v = (v << 1) | 32'(slv_cap[i]);
                        end
                        chk("mosi_nbits", 32'(slv_cap.size()), 32'(e.len));
                        chk("mosi_word", v, 32'(e.txm));
                    end
                end
                if (!busy) begin
                    rises = 0;
                    ss_bad = 0;
                end
            end
            prev_sck = sck;
        end
    end

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 500) begin
            @(negedge clk);
            i++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            chk("done_timeout", 32'(sb_q.size()), 32'(0));
            sb_q.delete();
        end
    endtask

    task automatic issue(input logic p_cpol, input logic p_cpha, input int p_div, input int p_len,
                         input int p_sel, input logic [DATA_W-1:0] p_tx, input logic [DATA_W-1:0] p_word,
                         input logic p_loop, input logic p_lsb);
        exp_t e;
        int n;
        logic [DATA_W-1:0] m;
        wait_idle();
        @(negedge clk);
        cpol     = p_cpol;
        cpha     = p_cpha;
        clk_div  = DIV_W'(p_div);
        xfer_len = LEN_W'(p_len);
        ss_sel   = SEL_W'(p_sel);
        tx_data  = p_tx;
`ifdef SPI_LSB_FIRST_EN
        lsb_first = p_lsb;
`endif
        n = eff_len(p_len);
        m = DATA_W'((32'd1 << n) - 1);
        loop_mode = p_loop;
        cur_cpol  = p_cpol;
        cur_cpha  = p_cpha;
        cur_len   = n;
        cur_lsb   = p_lsb;
        slv_word  = p_word;
        slv_miso  = 1'b0;
        @(negedge clk);
        chk("idle_sck", 32'(sck), 32'(p_cpol));
        e.rx    = (p_loop ? p_tx : p_word) & m;
        e.txm   = p_tx & m;
        e.lat   = (2 * n + 1) * (p_div + 1) + 1;
        e.issue = cyc;
        e.ss    = '1;
        if (p_sel < NUM_SS) e.ss[p_sel] = 1'b0;
        e.len   = n;
        e.cpol  = p_cpol;
        e.lsb   = p_lsb;
        sb_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; clk_div = '0;
        xfer_len = '0; ss_sel = '0; tx_data = '0;
`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sck", 32'(sck), 32'(0));
        chk("rst_mosi", 32'(mosi), 32'(0));
        chk("rst_mosi_oe", 32'(mosi_oe), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_ss_n", 32'(ss_n), 32'({NUM_SS{1'b1}}));
        chk("rst_rx_data", 32'(rx_data), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Mode 0, fastest SCK, looped back.
        issue(1'b0, 1'b0, 0, 8, 0, 8'hA5, 8'h00, 1'b1, 1'b0);
        drain(200);

        // Modes 1..3 against the slave model.
        for (int md = 1; md < 4; md++) begin
            issue(1'(md >> 1), 1'(md & 1), 3, 5, 1, 8'h13, 8'h0B, 1'b0, 1'b0);
            drain(200);
        end

        // Length boundaries and select 2.
        issue(1'b0, 1'b1, 1, 0, 2, 8'h3C, 8'hC6, 1'b0, 1'b0);
        drain(200);
        issue(1'b1, 1'b0, 0, DATA_W + 3, 2, 8'h81, 8'h7E, 1'b0, 1'b0);
        drain(200);
        issue(1'b0, 1'b0, 2, 1, 3, 8'hFF, 8'hFF, 1'b0, 1'b0);
        drain(200);

        // Stray start and input changes while a transfer runs.
        d0 = n_done;
        issue(1'b0, 1'b1, 1, 6, 1, 8'h2D, 8'h15, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        cpol     = ~cpol;
        cpha     = ~cpha;
        clk_div  = DIV_W'($urandom_range(0, 5));
        xfer_len = LEN_W'($urandom_range(0, 15));
        ss_sel   = SEL_W'($urandom_range(0, 3));
        tx_data  = DATA_W'($urandom);
        @(negedge clk);
        start = 1'b0;
        drain(300);
        repeat (40) @(negedge clk);
        chk("single_done", 32'(n_done - d0), 32'(1));

        // Reset in the middle of ACTIVE.
        issue(1'b0, 1'b0, 2, 8, 0, 8'h5A, 8'h00, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ss_n", 32'(ss_n), 32'({NUM_SS{1'b1}}));
        chk("abort_sck", 32'(sck), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_rx_data", 32'(rx_data), 32'(0));
        sb_q.delete();
        d0 = n_done;
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("abort_no_done", 32'(n_done - d0), 32'(0));
        issue(1'b0, 1'b0, 0, 8, 3, 8'hC3, 8'h00, 1'b1, 1'b0);
        drain(200);

`ifdef SPI_LSB_FIRST_EN
        issue(1'b0, 1'b0, 0, 8, 0, 8'h01, 8'h00, 1'b1, 1'b1);
        drain(200);
        issue(1'b1, 1'b1, 2, 5, 1, 8'h16, 8'h0D, 1'b0, 1'b1);
        drain(200);
`endif

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, NUM_SS - 1)),
                  DATA_W'($urandom), DATA_W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            drain(300);
        end

        repeat (20) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
